bus_master_if: RTL and testbench

- Per-core bus initiator for the dual-core shared-memory system bus.
- Sits between one CPU core's memory port and one requester slot of the round-robin system bus arbiter.
- Accepts a single load/store from the core, raises the bus request, waits for the grant, drives address/data/write-enable during the granted cycle and captures read data.
- Signals completion back to the core and records how many cycles the transaction waited for the bus.

---
 rtl/bus_master_if.sv | 68 ++++++
 tb/tb_bus_master_if.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// bus_master_if: per-core bus initiator that turns one core load/store into a granted bus access
module bus_master_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  input  logic             cpu_memwrite,
  output logic [WIDTH-1:0] cpu_readdata,
  output logic             cpu_done,
  output logic             cpu_busy,
  output logic             request,
  input  logic             grant,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic             memwrite,
  input  logic [WIDTH-1:0] readdata,
  output logic [CNTW-1:0]  last_wait
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_adr, r_wd, r_rd;
  logic             r_we, r_request;
  logic [CNTW-1:0]  r_cnt, r_last;
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // next state plus state-decoded outputs; memwrite is gated so a stale grant in DONE cannot write twice
  always_comb begin
    w_next   = r_state == IDLE ? (cpu_req ? REQ : IDLE) :
               r_state == REQ  ? (grant ? DONE : REQ) : IDLE;
    memwrite = r_we && r_state == REQ;
    cpu_done = r_state == DONE;
    cpu_busy = r_state != IDLE;
  end
  // request latch, wait counting and read-data capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_adr     <= '0;
      r_wd      <= '0;
      r_we      <= 1'b0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_last    <= '0;
      r_request <= 1'b0;
    end else if (r_state == IDLE && cpu_req) begin
      r_adr     <= cpu_adr;
      r_wd      <= cpu_writedata;
      r_we      <= cpu_memwrite;
      r_cnt     <= '0;
      r_request <= 1'b1;
    end else if (r_state == REQ && grant) begin
      if (!r_we) r_rd <= readdata;
      r_last    <= r_cnt;
      r_request <= 1'b0;
    end else if (r_state == REQ) begin
      r_cnt     <= r_cnt != '1 ? r_cnt + 1'b1 : r_cnt;
    end
  assign adr          = r_adr;
  assign writedata    = r_wd;
  assign cpu_readdata = r_rd;
  assign request      = r_request;
  assign last_wait    = r_last;
endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed vectors plus reset, saturation and two-core contention sequences
module tb_bus_master_if;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, arb_en = 1'b0;
  always #5 clk = ~clk;
  logic req0 = 0, we0 = 0, mg0 = 0, g0, ag0, ag1, tok;
  logic [7:0] cadr0 = 0, cwd0 = 0, rd0, adr0, wdo0, rdin0;
  logic done0, busy0, request0, mw0;
  logic [7:0] lw0;
  logic req1 = 0, we1 = 0, g1, done1, busy1, request1, mw1;
  logic [7:0] cadr1 = 0, cwd1 = 0, rd1, adr1, wdo1, rdin1, lw1;
  logic req2 = 0, mg2 = 0, done2, busy2, request2, mw2;
  logic [7:0] rd2, adr2, wdo2, rdin2;
  logic [2:0] lw2;
  int wcnt0, wcnt1, errors = 0, checks = 0;
  logic [7:0] wa0, wd0, wa1, wd1;
  assign g0 = arb_en ? ag0 : mg0;
  assign g1 = arb_en ? ag1 : 1'b0;
  assign rdin0 = adr0 ^ 8'h68;
  assign rdin1 = adr1 ^ 8'h68;
  assign rdin2 = adr2 ^ 8'h68;
  bus_master_if dut0 (.clk(clk), .reset(reset), .cpu_req(req0), .cpu_adr(cadr0), .cpu_writedata(cwd0),
    .cpu_memwrite(we0), .cpu_readdata(rd0), .cpu_done(done0), .cpu_busy(busy0), .request(request0),
    .grant(g0), .adr(adr0), .writedata(wdo0), .memwrite(mw0), .readdata(rdin0), .last_wait(lw0));
  bus_master_if dut1 (.clk(clk), .reset(reset), .cpu_req(req1), .cpu_adr(cadr1), .cpu_writedata(cwd1),
    .cpu_memwrite(we1), .cpu_readdata(rd1), .cpu_done(done1), .cpu_busy(busy1), .request(request1),
    .grant(g1), .adr(adr1), .writedata(wdo1), .memwrite(mw1), .readdata(rdin1), .last_wait(lw1));
  bus_master_if #(.CNTW(3)) dut2 (.clk(clk), .reset(reset), .cpu_req(req2), .cpu_adr(8'h44),
    .cpu_writedata(8'h55), .cpu_memwrite(1'b1), .cpu_readdata(rd2), .cpu_done(done2), .cpu_busy(busy2),
    .request(request2), .grant(mg2), .adr(adr2), .writedata(wdo2), .memwrite(mw2), .readdata(rdin2),
    .last_wait(lw2));
  // registered round-robin arbiter model; it re-grants from the stale request like the real arbiter
  always @(posedge clk)
    if (!arb_en) begin
      ag0 <= 0; ag1 <= 0; tok <= 0;
    end else if (request0 && request1) begin
      ag0 <= !tok; ag1 <= tok; tok <= !tok;
    end else begin
      ag0 <= request0; ag1 <= request1;
    end
  // memory-side write log; the arbiter replaces the address MSB with the core id
  always @(posedge clk)
    if (clr) begin
      wcnt0 <= 0; wcnt1 <= 0; wa0 <= 0; wd0 <= 0; wa1 <= 0; wd1 <= 0;
    end else begin
      if (g0 && mw0) begin wcnt0 <= wcnt0 + 1; wa0 <= {1'b0, adr0[6:0]}; wd0 <= wdo0; end
      if (g1 && mw1) begin wcnt1 <= wcnt1 + 1; wa1 <= {1'b1, adr1[6:0]}; wd1 <= wdo1; end
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  typedef struct {
    logic [7:0] adr;
    logic [7:0] wd;
    logic       we;
    int         gd;
    logic [7:0] lw;
    logic [7:0] rd;
    int         nw;
  } vec_t;
  vec_t v[6];
  int nd0, nd1, t0, t1, bad;
  initial begin
    v[0] = '{8'h12, 8'hA5, 1'b1, 0, 8'd0, 8'h00, 1};
    v[1] = '{8'h34, 8'h00, 1'b0, 0, 8'd0, 8'h5C, 0};
    v[2] = '{8'h56, 8'h77, 1'b1, 2, 8'd2, 8'h5C, 1};
    v[3] = '{8'h1A, 8'h3C, 1'b1, 5, 8'd5, 8'h5C, 1};
    v[4] = '{8'h70, 8'h99, 1'b0, 1, 8'd1, 8'h18, 0};
    v[5] = '{8'h7F, 8'h01, 1'b1, 0, 8'd0, 8'h18, 1};
    repeat (2) @(negedge clk);
    chk("rst_request", request0, 0);
    chk("rst_memwrite", mw0, 0);
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_adr", adr0, 0);
    chk("rst_wdata", wdo0, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_last_wait", lw0, 0);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clr = 1; req0 = 1; cadr0 = v[i].adr; cwd0 = v[i].wd; we0 = v[i].we; mg0 = 0;
      @(negedge clk);
      clr = 0; req0 = 0; cadr0 = ~v[i].adr; cwd0 = ~v[i].wd; we0 = ~v[i].we;
      chk("req_up", request0, 1);
      chk("busy_req", busy0, 1);
      for (int c = 0; c < v[i].gd; c++) begin
        @(negedge clk);
        chk("req_held", request0, 1);
      end
      mg0 = 1;
      chk("grant_memwrite", mw0, v[i].we);
      chk("grant_adr", adr0, v[i].adr);
      chk("grant_wdata", wdo0, v[i].wd);
      @(negedge clk);
      chk("done_pulse", done0, 1);
      chk("done_memwrite", mw0, 0);
      chk("done_request", request0, 0);
      chk("done_busy", busy0, 1);
      chk("last_wait", lw0, v[i].lw);
      chk("readdata", rd0, v[i].rd);
      mg0 = 0;
      @(negedge clk);
      chk("done_gone", done0, 0);
      chk("idle_busy", busy0, 0);
      chk("write_count", wcnt0, v[i].nw);
      if (v[i].nw != 0) begin
        chk("mem_adr", wa0, v[i].adr);
        chk("mem_data", wd0, v[i].wd);
      end
      chk("readdata_held", rd0, v[i].rd);
    end
    @(negedge clk);
    clr = 1; req0 = 1; cadr0 = 8'h22; cwd0 = 8'h33; we0 = 1;
    @(negedge clk);
    clr = 0; req0 = 0;
    chk("mid_req", request0, 1);
    chk("mid_memwrite", mw0, 1);
    #2 reset = 1;
    #1;
    chk("arst_request", request0, 0);
    chk("arst_memwrite", mw0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_done", done0, 0);
    @(negedge clk);
    reset = 0; mg0 = 1; bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done0 || request0 || mw0) bad++;
    end
    mg0 = 0;
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_writes", wcnt0, 0);
    chk("post_rst_last_wait", lw0, 0);
    @(negedge clk);
    req2 = 1;
    @(negedge clk);
    req2 = 0;
    repeat (10) @(negedge clk);
    chk("sat_req_held", request2, 1);
    mg2 = 1;
    @(negedge clk);
    mg2 = 0;
    chk("sat_done", done2, 1);
    chk("sat_last_wait", lw2, 7);
    @(negedge clk);
    clr = 1; arb_en = 1;
    req0 = 1; cadr0 = 8'h03; cwd0 = 8'h11; we0 = 1;
    req1 = 1; cadr1 = 8'h05; cwd1 = 8'h22; we1 = 1;
    nd0 = 0; nd1 = 0; t0 = -1; t1 = -1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) begin req0 = 0; req1 = 0; clr = 0; end
      if (done0) begin nd0++; t0 = c; end
      if (done1) begin nd1++; t1 = c; end
    end
    arb_en = 0;
    chk("c0_writes", wcnt0, 1);
    chk("c0_mem_adr", wa0, 8'h03);
    chk("c0_mem_data", wd0, 8'h11);
    chk("c1_writes", wcnt1, 1);
    chk("c1_mem_adr", wa1, 8'h85);
    chk("c1_mem_data", wd1, 8'h22);
    chk("c0_done_count", nd0, 1);
    chk("c1_done_count", nd1, 1);
    chk("c0_done_cycle", t0, 2);
    chk("c1_done_cycle", t1, 3);
    chk("c0_last_wait", lw0, 1);
    chk("c1_last_wait", lw1, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
